ips2l_pcie_dma_rd_ctrl: RTL and testbench

Read-side counterpart of the BAR RAM write controller in the PCIe DMA example design. Accepts one memory-read request (DW address, DW length, BAR hit), fetches the 128-bit RAM lines, realigns the DWs so the first requested DW sits in lane 0, and streams completion payload beats to the completion TLP builder. Downstream back-pressure is absorbed by a 4-entry line FIFO with credit-based RAM read issue.

---
 rtl/ips2l_pcie_dma_pkg.sv | 39 +++
 rtl/ips2l_pcie_dma_rd_ctrl_if.sv | 35 +++
 rtl/ips2l_pcie_dma_rd_fifo.sv | 51 +++++
 rtl/ips2l_pcie_dma_rd_ctrl.sv | 160 ++++++++++++++++
 tb/tb_ips2l_pcie_dma_rd_ctrl.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/ips2l_pcie_dma_pkg.sv
// Shared types, sizes and decode helpers for the PCIe DMA BAR RAM read path.
package ips2l_pcie_dma_pkg;

    localparam int unsigned LINE_DW    = 4;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned DW_W       = 32;
    localparam int unsigned LINE_W     = LINE_DW * DW_W;
    localparam int unsigned LEN_W      = 11;
    localparam int unsigned CNT_W      = 9;
    localparam int unsigned FCNT_W     = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } rd_state_e;

    typedef struct packed {
        logic [LINE_W-1:0]  data;
        logic [LINE_DW-1:0] dw_vld;
        logic               first;
        logic               last;
    } beat_t;

    // A zero length field encodes the maximum 1024-DW request.
    function automatic logic [LEN_W-1:0] decode_len(input logic [9:0] len);
        return (len == 10'd0) ? 11'd1024 : {1'b0, len};
    endfunction

    function automatic logic [LINE_DW-1:0] last_dw_vld(input logic [1:0] len_lsb);
        case (len_lsb)
            2'd1:    return 4'b0001;
            2'd2:    return 4'b0011;
            2'd3:    return 4'b0111;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/ips2l_pcie_dma_rd_ctrl_if.sv
// Request, RAM read port and completion payload stream of the DMA read controller.
interface ips2l_pcie_dma_rd_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = 9
);
    import ips2l_pcie_dma_pkg::*;

    logic                  i_rd_req;
    logic [9:0]            i_length;
    logic [63:0]           i_addr;
    logic [1:0]            i_bar_hit;
    logic                  o_busy;
    logic                  o_rd_en;
    logic [ADDR_WIDTH-1:0] o_rd_addr;
    logic [1:0]            o_rd_bar_hit;
    logic [LINE_W-1:0]     i_rd_data;
    logic                  o_data_vld;
    logic                  i_data_rdy;
    logic [LINE_W-1:0]     o_data;
    logic [LINE_DW-1:0]    o_dw_vld;
    logic                  o_first;
    logic                  o_last;

    modport slave (
        input  i_rd_req, i_length, i_addr, i_bar_hit, i_rd_data, i_data_rdy,
        output o_busy, o_rd_en, o_rd_addr, o_rd_bar_hit,
        output o_data_vld, o_data, o_dw_vld, o_first, o_last
    );

    modport master (
        output i_rd_req, i_length, i_addr, i_bar_hit, i_rd_data, i_data_rdy,
        input  o_busy, o_rd_en, o_rd_addr, o_rd_bar_hit,
        input  o_data_vld, o_data, o_dw_vld, o_first, o_last
    );

endinterface

// File: rtl/ips2l_pcie_dma_rd_fifo.sv
// 4-deep line FIFO exposing the head line and the one behind it for DW realignment.
module ips2l_pcie_dma_rd_fifo
    import ips2l_pcie_dma_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [LINE_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic              clr,
    output logic [LINE_W-1:0] head,
    output logic [LINE_W-1:0] next,
    output logic [FCNT_W-1:0] count
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

    logic [LINE_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  rd_ptr_nx;
    logic [FCNT_W-1:0] cnt;

    assign rd_ptr_nx = rd_ptr + PTR_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
            if (rd_en) rd_ptr <= rd_ptr_nx;
            cnt <= cnt + FCNT_W'(wr_en) - FCNT_W'(rd_en);
        end
    end

    // Line storage needs no reset: nothing downstream looks at it while empty.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

    assign head  = mem[rd_ptr];
    assign next  = mem[rd_ptr_nx];
    assign count = cnt;

endmodule

// File: rtl/ips2l_pcie_dma_rd_ctrl.sv
// BAR RAM read controller: fetches RAM lines for one read request and streams DW-aligned payload beats.
module ips2l_pcie_dma_rd_ctrl
    import ips2l_pcie_dma_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 9
) (
    input  logic                     clk,
    input  logic                     rst_n,
    ips2l_pcie_dma_rd_ctrl_if.slave  bus
);

    rd_state_e             state_q, state_d;
    logic                  busy_q;
    logic                  rd_en_q, rd_en_d;
    logic                  rd_vld_q;
    logic [ADDR_WIDTH-1:0] rd_addr_q;
    logic [1:0]            rd_bar_q;
    logic [1:0]            len_lsb_q;
    logic [1:0]            pos_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [CNT_W-1:0]      nlines_q, nbeats_q;
    logic [CNT_W-1:0]      line_idx_q, beat_idx_q;

    logic                  accept;
    logic [LEN_W-1:0]      len_dec;
    logic [CNT_W-1:0]      nlines_in, nbeats_in;
    logic [LINE_W-1:0]     fifo_head, fifo_next;
    logic [FCNT_W-1:0]     fifo_count;
    logic                  need_next, is_last, beat_vld, xfer, pop, clr, issue_ok;
    logic [3:0]            credit_used;
    logic [2*LINE_W-1:0]   pair;
    logic [LINE_W-1:0]     aligned;
    logic [LINE_DW-1:0]    dw_vld;
    beat_t                 beat_c;
    logic                  addr_unused;

    assign addr_unused = ^{bus.i_addr[63:ADDR_WIDTH+4], bus.i_addr[1:0]};

    // Request decode
    assign accept    = bus.i_rd_req & ~busy_q;
    assign len_dec   = decode_len(bus.i_length);
    assign nlines_in = CNT_W'((len_dec + LEN_W'(bus.i_addr[3:2]) + LEN_W'(3)) >> 2);
    assign nbeats_in = CNT_W'((len_dec + LEN_W'(3)) >> 2);

    ips2l_pcie_dma_rd_fifo u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (rd_vld_q),
        .wr_data (bus.i_rd_data),
        .rd_en   (pop),
        .clr     (clr),
        .head    (fifo_head),
        .next    (fifo_next),
        .count   (fifo_count)
    );

    // A beat straddles two lines unless it is line-aligned or the request has no further line.
    assign need_next = (pos_q != 2'd0) && ((beat_idx_q + CNT_W'(1)) < nlines_q);
    assign is_last   = (beat_idx_q == nbeats_q - CNT_W'(1));
    assign beat_vld  = (state_q != ST_IDLE) &&
                       (need_next ? (fifo_count >= FCNT_W'(2)) : (fifo_count != '0));
    assign xfer      = beat_vld & bus.i_data_rdy;
    // Final beat flushes whatever is left, including a trailing line it only partly used.
    assign pop       = xfer & ~is_last;
    assign clr       = xfer & is_last;

    // Lines queued plus lines in flight may never exceed the FIFO depth.
    assign credit_used = 4'(fifo_count) + 4'(rd_en_q) + 4'(rd_vld_q);
    assign issue_ok    = credit_used < (4'(FIFO_DEPTH) + 4'(pop));

    // Aligner: shift the two-line window right by the start DW offset.
    always_comb begin
        pair    = {fifo_next, fifo_head};
        aligned = fifo_head;
        case (pos_q)
            2'd1:    aligned = pair[LINE_W+31:32];
            2'd2:    aligned = pair[LINE_W+63:64];
            2'd3:    aligned = pair[LINE_W+95:96];
            default: aligned = fifo_head;
        endcase
        dw_vld = is_last ? last_dw_vld(len_lsb_q) : 4'b1111;
        beat_c = '0;
        if (beat_vld) begin
            for (int j = 0; j < LINE_DW; j++) begin
                beat_c.data[j*DW_W +: DW_W] = dw_vld[j] ? aligned[j*DW_W +: DW_W] : '0;
            end
            beat_c.dw_vld = dw_vld;
            beat_c.first  = (beat_idx_q == '0);
            beat_c.last   = is_last;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        rd_en_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_READ;
            end
            ST_READ: begin
                rd_en_d = issue_ok;
                if (issue_ok && (line_idx_q == nlines_q - CNT_W'(1))) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (clr) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            rd_en_q    <= 1'b0;
            rd_vld_q   <= 1'b0;
            rd_addr_q  <= '0;
            rd_bar_q   <= '0;
            len_lsb_q  <= '0;
            pos_q      <= '0;
            base_q     <= '0;
            nlines_q   <= '0;
            nbeats_q   <= '0;
            line_idx_q <= '0;
            beat_idx_q <= '0;
        end else begin
            state_q  <= state_d;
            busy_q   <= (state_d != ST_IDLE);
            rd_en_q  <= rd_en_d;
            rd_vld_q <= rd_en_q;
            if (accept) begin
                len_lsb_q  <= len_dec[1:0];
                pos_q      <= bus.i_addr[3:2];
                base_q     <= bus.i_addr[ADDR_WIDTH+3:4];
                rd_bar_q   <= bus.i_bar_hit;
                nlines_q   <= nlines_in;
                nbeats_q   <= nbeats_in;
                line_idx_q <= '0;
                beat_idx_q <= '0;
            end
            if (rd_en_d) begin
                rd_addr_q  <= base_q + ADDR_WIDTH'(line_idx_q);
                line_idx_q <= line_idx_q + CNT_W'(1);
            end
            if (pop) beat_idx_q <= beat_idx_q + CNT_W'(1);
        end
    end

    assign bus.o_busy       = busy_q;
    assign bus.o_rd_en      = rd_en_q;
    assign bus.o_rd_addr    = rd_addr_q;
    assign bus.o_rd_bar_hit = rd_bar_q;
    assign bus.o_data_vld   = beat_vld;
    assign bus.o_data       = beat_c.data;
    assign bus.o_dw_vld     = beat_c.dw_vld;
    assign bus.o_first      = beat_c.first;
    assign bus.o_last       = beat_c.last;

endmodule

// File: tb/tb_ips2l_pcie_dma_rd_ctrl.sv
// Directed bench for the DMA read controller with a behavioural 1-cycle-latency BAR RAM.
module tb_ips2l_pcie_dma_rd_ctrl;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    ips2l_pcie_dma_rd_ctrl_if #(.ADDR_WIDTH(9)) bif ();

    ips2l_pcie_dma_rd_ctrl #(.ADDR_WIDTH(9)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // DW value encodes the BAR and the DW index inside the 2048-DW RAM.
    function automatic logic [31:0] dwval(input logic [1:0] bar, input logic [10:0] idx);
        return {6'h28, bar, 13'd0, idx};
    endfunction

    function automatic logic [127:0] line_val(input logic [1:0] bar, input logic [8:0] line);
        logic [127:0] v;
        for (int j = 0; j < 4; j++) v[32*j +: 32] = dwval(bar, {line, 2'(j)});
        return v;
    endfunction

    always @(posedge clk) begin
        if (bif.o_rd_en) bif.i_rd_data <= line_val(bif.o_rd_bar_hit, bif.o_rd_addr);
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_busy"},    128'(bif.o_busy),       128'(0));
        chk({tag, "_rd_en"},   128'(bif.o_rd_en),      128'(0));
        chk({tag, "_rd_addr"}, 128'(bif.o_rd_addr),    128'(0));
        chk({tag, "_bar"},     128'(bif.o_rd_bar_hit), 128'(0));
        chk({tag, "_vld"},     128'(bif.o_data_vld),   128'(0));
        chk({tag, "_data"},    bif.o_data,             128'(0));
        chk({tag, "_dw_vld"},  128'(bif.o_dw_vld),     128'(0));
        chk({tag, "_first"},   128'(bif.o_first),      128'(0));
        chk({tag, "_last"},    128'(bif.o_last),       128'(0));
    endtask

    // Issue one request and follow it to the last beat, checking reads, beats and timing.
    task automatic do_req(input logic [63:0] addr, input int len, input logic [1:0] bar,
                          input int rdy_pct, input bit poke);
        int           pos, nlines, nbeats, lastn, exp_vld_cyc;
        int           nreads, beat, first_rd, first_vld, last_cyc;
        logic [8:0]   line0;
        logic [10:0]  start;
        logic         stalled, rdy, lane_ok;
        logic [127:0] held_data, exp_data;
        logic [3:0]   held_dw, exp_dw;
        logic         held_first, held_last;

        pos         = int'(addr[3:2]);
        nlines      = (len + pos + 3) / 4;
        nbeats      = (len + 3) / 4;
        lastn       = (len % 4 == 0) ? 4 : len % 4;
        exp_vld_cyc = (pos == 0 || nlines == 1) ? 3 : 4;
        line0       = addr[12:4];
        start       = addr[12:2];
        nreads = 0; beat = 0; first_rd = -1; first_vld = -1; last_cyc = -1;
        stalled = 1'b0; held_data = '0; held_dw = '0; held_first = 1'b0; held_last = 1'b0;

        @(negedge clk);
        bif.i_rd_req   = 1'b1;
        bif.i_length   = 10'(len);
        bif.i_addr     = addr;
        bif.i_bar_hit  = bar;
        bif.i_data_rdy = 1'b0;
        @(negedge clk);
        bif.i_rd_req = 1'b0;
        chk("busy_after_accept", 128'(bif.o_busy), 128'(1));
        chk("rd_bar_hit", 128'(bif.o_rd_bar_hit), 128'(bar));

        for (int cyc = 0; cyc < 4000 && last_cyc < 0; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (poke && cyc == 1) begin
                bif.i_rd_req  = 1'b1;
                bif.i_addr    = addr ^ 64'h50;
                bif.i_length  = 10'd7;
                bif.i_bar_hit = ~bar;
            end
            if (poke && cyc == 2) bif.i_rd_req = 1'b0;
            if (bif.o_rd_en) begin
                if (first_rd < 0) first_rd = cyc;
                chk("rd_addr", 128'(bif.o_rd_addr), 128'(9'(line0 + 9'(nreads))));
                nreads++;
            end
            if (stalled) begin
                chk("stall_vld",   128'(bif.o_data_vld), 128'(1));
                chk("stall_data",  bif.o_data,           held_data);
                chk("stall_dw",    128'(bif.o_dw_vld),   128'(held_dw));
                chk("stall_first", 128'(bif.o_first),    128'(held_first));
                chk("stall_last",  128'(bif.o_last),     128'(held_last));
            end
            if (bif.o_data_vld) begin
                if (first_vld < 0) first_vld = cyc;
                for (int j = 0; j < 4; j++) begin
                    lane_ok = (beat < nbeats - 1) || (j < lastn);
                    exp_dw[j] = lane_ok;
                    exp_data[32*j +: 32] = lane_ok ? dwval(bar, start + 11'(4*beat + j)) : 32'd0;
                end
                chk("beat_data",  bif.o_data,         exp_data);
                chk("beat_dw",    128'(bif.o_dw_vld), 128'(exp_dw));
                chk("beat_first", 128'(bif.o_first),  128'(beat == 0));
                chk("beat_last",  128'(bif.o_last),   128'(beat == nbeats - 1));
                rdy = ($urandom_range(99) < rdy_pct);
                bif.i_data_rdy = rdy;
                stalled    = ~rdy;
                held_data  = bif.o_data;
                held_dw    = bif.o_dw_vld;
                held_first = bif.o_first;
                held_last  = bif.o_last;
                if (rdy) begin
                    beat++;
                    if (beat == nbeats) last_cyc = cyc;
                end
            end else begin
                bif.i_data_rdy = ($urandom_range(99) < rdy_pct);
                stalled = 1'b0;
            end
        end

        chk("completed_in_budget", 128'(last_cyc >= 0), 128'(1));
        chk("first_rd_cycle", 128'(first_rd), 128'(1));
        chk("first_vld_cycle", 128'(first_vld), 128'(exp_vld_cyc));
        chk("ram_reads", 128'(nreads), 128'(nlines));
        if (rdy_pct == 100) chk("no_bubbles", 128'(last_cyc), 128'(first_vld + nbeats - 1));
        @(negedge clk);
        bif.i_data_rdy = 1'b0;
        chk("busy_clear", 128'(bif.o_busy), 128'(0));
        chk("vld_clear", 128'(bif.o_data_vld), 128'(0));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bif.i_rd_req   = 1'b0;
        bif.i_length   = '0;
        bif.i_addr     = '0;
        bif.i_bar_hit  = '0;
        bif.i_data_rdy = 1'b0;
        bif.i_rd_data  = '0;

        repeat (3) @(negedge clk);
        chk_idle_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        do_req(64'h0,    4,    2'd0, 100, 1'b0);
        do_req(64'h8,    5,    2'd1, 100, 1'b0);
        do_req(64'hC,    1,    2'd2, 100, 1'b0);
        do_req(64'h4,    1024, 2'd3, 50,  1'b0);
        do_req(64'h1FF0, 8,    2'd1, 100, 1'b1);
        do_req(64'h14,   40,   2'd2, 100, 1'b0);

        // Reset in the middle of a stalled payload.
        @(negedge clk);
        bif.i_rd_req   = 1'b1;
        bif.i_length   = 10'd16;
        bif.i_addr     = 64'h0;
        bif.i_bar_hit  = 2'd1;
        bif.i_data_rdy = 1'b0;
        @(negedge clk);
        bif.i_rd_req = 1'b0;
        repeat (5) @(negedge clk);
        chk("pre_reset_vld", 128'(bif.o_data_vld), 128'(1));
        #2 rst_n = 1'b0;
        #1 chk_idle_outputs("async_reset");
        @(posedge clk);
        #1 chk_idle_outputs("reset_held");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_req(64'h10, 3, 2'd0, 100, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
